conv_seq_ctrl: RTL and testbench

Sequencer in front of the convolution layer. Captures six 6-bit switch rows into a 6x6 image buffer using a debounced-by-sync strobe. On start, it raster-scans every valid 3x3 window position (4x4 = 16 positions) and presents each window to the conv datapath through a valid/ready handshake. Sits between the top-level switch inputs and the conv layer, replacing ad-hoc row capture at top level.

---
 rtl/conv_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv_seq_ctrl
//  Purpose  : Sequencer in front of the convolution layer. Switch rows are
//             captured one per strobe edge into an IMG x IMG image buffer.
//             A start edge then raster-scans every KxK window position and
//             offers each window to the conv datapath over valid/ready.
//  Ports    :
//    clk          clock
//    rst_n        asynchronous active-low reset
//    row_in       switch row data, bit c = image column c
//    row_strobe   async switch, each rising edge stores one row
//    start        async switch, rising edge begins the scan (FULL only)
//    clear        async switch, rising edge discards image, back to LOAD
//    out_ready    conv datapath accepts the current window
//    win_valid    window outputs valid (high throughout SCAN)
//    win_bits     KxK window, bit K*i+j = img[win_row+i][win_col+j]
//    win_row      window top row    (0..P-1)
//    win_col      window left column (0..P-1)
//    rows_loaded  rows captured so far (0..IMG)
//    busy         high in SCAN
//    done         high in DONE
//  Revision : 1.0 - initial release
// ============================================================================
module conv_seq_ctrl #(
  parameter int IMG = 6,
  parameter int K   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IMG-1:0] row_in,
  input  logic           row_strobe,
  input  logic           start,
  input  logic           clear,
  input  logic           out_ready,
  output logic           win_valid,
  output logic [K*K-1:0] win_bits,
  output logic [2:0]     win_row,
  output logic [2:0]     win_col,
  output logic [2:0]     rows_loaded,
  output logic           busy,
  output logic           done
);

  // Window positions per axis and the terminal counter values.
  localparam int         P      = IMG - K + 1;
  localparam logic [2:0] C_LAST = 3'(P - 1);
  localparam logic [2:0] C_IMG  = 3'(IMG);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FULL = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     rows_q, rows_d;
  logic [2:0]     row_q, row_d;
  logic [2:0]     col_q, col_d;
  logic [IMG-1:0] img_q [IMG];
  logic           img_we_d;

  // --------------------------------------------------------------------------
  // Switch conditioning: two synchroniser flops plus a third flop for edge
  // detection. Bit 0 is the first flop; the pulse is s2 & ~s3 and lasts one
  // cycle, so a held switch produces exactly one action.
  // --------------------------------------------------------------------------
  logic [2:0] strobe_sync_q;
  logic [2:0] start_sync_q;
  logic [2:0] clear_sync_q;
  logic       w_strobe_pulse;
  logic       w_start_pulse;
  logic       w_clear_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync_q <= 3'b000;
      start_sync_q  <= 3'b000;
      clear_sync_q  <= 3'b000;
    end else begin
      strobe_sync_q <= {strobe_sync_q[1:0], row_strobe};
      start_sync_q  <= {start_sync_q[1:0],  start};
      clear_sync_q  <= {clear_sync_q[1:0],  clear};
    end
  end

  assign w_strobe_pulse = strobe_sync_q[1] & ~strobe_sync_q[2];
  assign w_start_pulse  = start_sync_q[1]  & ~start_sync_q[2];
  assign w_clear_pulse  = clear_sync_q[1]  & ~clear_sync_q[2];

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      rows_q  <= 3'd0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. clear overrides everything; start is only honoured in
  // FULL and strobe only in LOAD, which realises clear > start > strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    row_d    = row_q;
    col_d    = col_q;
    img_we_d = 1'b0;

    if (w_clear_pulse) begin
      // The image buffer is deliberately kept; the next loads overwrite it.
      state_d = ST_LOAD;
      rows_d  = 3'd0;
      row_d   = 3'd0;
      col_d   = 3'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (w_strobe_pulse) begin
            img_we_d = 1'b1;
            rows_d   = rows_q + 3'd1;
            if (rows_q + 3'd1 == C_IMG) begin
              state_d = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (w_start_pulse) begin
            state_d = ST_SCAN;
            row_d   = 3'd0;
            col_d   = 3'd0;
          end
        end
        ST_SCAN: begin
          if (out_ready) begin
            if (col_q != C_LAST) begin
              col_d = col_q + 3'd1;
            end else if (row_q != C_LAST) begin
              col_d = 3'd0;
              row_d = row_q + 3'd1;
            end else begin
              // Final window accepted: indices hold at their terminal value.
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Held until clear or reset.
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Image buffer. row_in is sampled directly: switches are held stable well
  // beyond the synchroniser latency, so no metastability path exists here.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < IMG; r++) begin
        img_q[r] <= '0;
      end
    end else if (img_we_d) begin
      img_q[rows_q] <= row_in;
    end
  end

  // --------------------------------------------------------------------------
  // Window extraction, purely combinational from buffer and current indices.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < K; gi++) begin : g_win_row
    for (genvar gj = 0; gj < K; gj++) begin : g_win_col
      logic [2:0] w_r;
      logic [2:0] w_c;
      assign w_r = row_q + 3'(gi);
      assign w_c = col_q + 3'(gj);
      assign win_bits[K*gi+gj] = img_q[w_r][w_c];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign win_valid   = (state_q == ST_SCAN);
  assign busy        = (state_q == ST_SCAN);
  assign done        = (state_q == ST_DONE);
  assign win_row     = row_q;
  assign win_col     = col_q;
  assign rows_loaded = rows_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_seq_ctrl
//  Purpose  : Scoreboard bench for conv_seq_ctrl. Stimulus pushes expected
//             windows into a queue; a negedge monitor compares every
//             presented window against the queue head and pops on transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] row_in;
  logic       row_strobe;
  logic       start;
  logic       clear;
  logic       out_ready;
  logic       win_valid;
  logic [8:0] win_bits;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic [2:0] rows_loaded;
  logic       busy;
  logic       done;

  conv_seq_ctrl #(.IMG(6), .K(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_in      (row_in),
    .row_strobe  (row_strobe),
    .start       (start),
    .clear       (clear),
    .out_ready   (out_ready),
    .win_valid   (win_valid),
    .win_bits    (win_bits),
    .win_row     (win_row),
    .win_col     (win_col),
    .rows_loaded (rows_loaded),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic [2:0] r;
    logic [2:0] c;
    logic [8:0] b;
  } win_t;

  int         checks = 0;
  int         errors = 0;
  int         xfers  = 0;
  int         x0;
  logic [5:0] img_m [6];
  int         m_rows;
  win_t       exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Raise the selected switches, wait for the action edge, lower them.
  // Entered and left at posedge+1.
  task automatic pulse(input logic s, input logic st, input logic cl);
    row_strobe = s;
    start      = st;
    clear      = cl;
    repeat (3) @(posedge clk);
    #1;
    row_strobe = 1'b0;
    start      = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [5:0] v, input int exp_rows);
    row_in = v;
    pulse(1'b1, 1'b0, 1'b0);
    if (m_rows < 6) begin
      img_m[m_rows] = v;
      m_rows++;
    end
    chk("rows_loaded", int'(rows_loaded), exp_rows);
    idle(3);
  endtask

  task automatic load6(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                       input logic [5:0] d, input logic [5:0] e, input logic [5:0] f);
    load_row(a, 1); load_row(b, 2); load_row(c, 3);
    load_row(d, 4); load_row(e, 5); load_row(f, 6);
  endtask

  function automatic win_t mkwin(input int r, input int c);
    win_t w;
    w.r = 3'(r);
    w.c = 3'(c);
    w.b = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.b[3*i+j] = img_m[r+i][c+j];
    return w;
  endfunction

  task automatic push_windows(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(mkwin(k / 4, k % 4));
  endtask

  // Monitor: a presented window must match the queue head; held windows are
  // re-checked every cycle, and the head pops only on a transfer.
  always @(negedge clk) begin
    if (rst_n && win_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window row=%0d col=%0d bits=0x%0h", win_row, win_col, win_bits);
      end else begin
        if (win_row !== exp_q[0].r || win_col !== exp_q[0].c || win_bits !== exp_q[0].b) begin
          errors++;
          $display("FAIL window actual=(%0d,%0d,0x%0h) expected=(%0d,%0d,0x%0h)",
                   win_row, win_col, win_bits, exp_q[0].r, exp_q[0].c, exp_q[0].b);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; row_in = '0; row_strobe = 1'b0; start = 1'b0; clear = 1'b0; out_ready = 1'b0;
    m_rows = 0;
    for (int r = 0; r < 6; r++) img_m[r] = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("reset_rows_loaded", int'(rows_loaded), 0);
    chk("reset_win_valid", int'(win_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_win_row", int'(win_row), 0);
    chk("reset_win_col", int'(win_col), 0);

    // Diagonal image; a 7th strobe must not overwrite row 5.
    load6(6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20);
    load_row(6'h3F, 6);

    // Streaming scan with out_ready held high.
    out_ready = 1'b1;
    push_windows(16);
    x0 = xfers;
    pulse(1'b0, 1'b1, 1'b0);
    chk("first_valid", int'(win_valid), 1);
    chk("first_bits", int'(win_bits), 'h111);
    chk("first_busy", int'(busy), 1);
    idle(15);
    chk("last_row", int'(win_row), 3);
    chk("last_col", int'(win_col), 3);
    chk("last_bits_row5_kept", int'(win_bits), 'h111);
    idle(1);
    chk("stream_done", int'(done), 1);
    chk("stream_busy", int'(busy), 0);
    chk("stream_valid_drop", int'(win_valid), 0);
    chk("stream_xfers", xfers - x0, 16);
    chk("stream_queue_empty", exp_q.size(), 0);

    // start ignored in DONE, clear returns to LOAD.
    pulse(1'b0, 1'b1, 1'b0);
    chk("done_start_ignored_done", int'(done), 1);
    chk("done_start_ignored_busy", int'(busy), 0);
    idle(3);
    pulse(1'b0, 1'b0, 1'b1);
    m_rows = 0;
    chk("clear_done", int'(done), 0);
    chk("clear_rows", int'(rows_loaded), 0);
    idle(3);

    // Partial load: start ignored, then completes and scans with toggled ready.
    load_row(6'h3F, 1); load_row(6'h2A, 2); load_row(6'h15, 3);
    pulse(1'b0, 1'b1, 1'b0);
    chk("partial_start_busy", int'(busy), 0);
    chk("partial_start_rows", int'(rows_loaded), 3);
    idle(3);
    load_row(6'h33, 4); load_row(6'h0C, 5); load_row(6'h21, 6);
    out_ready = 1'b0;
    push_windows(16);
    x0 = xfers;
    pulse(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) begin
      out_ready = k[0];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    chk("toggle_done", int'(done), 1);
    chk("toggle_xfers", xfers - x0, 16);
    pulse(1'b0, 1'b0, 1'b1);
    m_rows = 0;
    idle(3);

    // Clear while window (2,1) is held.
    load6(6'h07, 6'h38, 6'h15, 6'h2A, 6'h3C, 6'h0F);
    out_ready = 1'b1;
    push_windows(10);
    pulse(1'b0, 1'b1, 1'b0);
    idle(9);
    out_ready = 1'b0;
    chk("abort_at_row", int'(win_row), 2);
    chk("abort_at_col", int'(win_col), 1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("abort_valid", int'(win_valid), 0);
    chk("abort_rows", int'(rows_loaded), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_pending_window", exp_q.size(), 1);
    exp_q.delete();
    m_rows = 0;
    idle(3);
    pulse(1'b0, 1'b1, 1'b0);
    chk("post_clear_start_busy", int'(busy), 0);
    chk("post_clear_start_rows", int'(rows_loaded), 0);
    idle(3);

    // Asynchronous reset mid-scan.
    load6(6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    push_windows(1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("prereset_bits", int'(win_bits), 'h1FF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(win_valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_rows", int'(rows_loaded), 0);
    chk("async_row", int'(win_row), 0);
    chk("async_col", int'(win_col), 0);
    chk("async_bits", int'(win_bits), 0);
    exp_q.delete();
    m_rows = 0;
    for (int r = 0; r < 6; r++) img_m[r] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Simultaneous clear and start from FULL: clear wins.
    load6(6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20);
    pulse(1'b0, 1'b1, 1'b1);
    m_rows = 0;
    chk("clr_start_rows", int'(rows_loaded), 0);
    chk("clr_start_busy", int'(busy), 0);
    chk("clr_start_valid", int'(win_valid), 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
